// File: rtl/avr_core_pkg.sv
// Shared AVR core definitions: program-memory geometry, 32-bit opcode decode
// and the fetch-stage state and queue-entry types.
package avr_core_pkg;

  localparam int PM_AW = 14;
  localparam int PM_DW = 16;

  // LDS/STS and JMP/CALL carry a second word (address or immediate).
  localparam logic [PM_DW-1:0] OPC32_LDSTS_MASK    = 16'hFC0F;
  localparam logic [PM_DW-1:0] OPC32_LDSTS_MATCH   = 16'h9000;
  localparam logic [PM_DW-1:0] OPC32_JMPCALL_MASK  = 16'hFE0C;
  localparam logic [PM_DW-1:0] OPC32_JMPCALL_MATCH = 16'h940C;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PM_AW-1:0] pc;
    logic [PM_DW-1:0] word;
  } qent_t;

  function automatic logic is_32bit_opcode(input logic [PM_DW-1:0] w);
    return ((w & OPC32_LDSTS_MASK) == OPC32_LDSTS_MATCH) ||
           ((w & OPC32_JMPCALL_MASK) == OPC32_JMPCALL_MATCH);
  endfunction

endpackage

// File: rtl/prog_word_queue.sv
// Circular FIFO of {pc, word} entries with single- or double-word pop,
// occupancy count and synchronous clear.
module prog_word_queue
  import avr_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  qent_t                    push_ent,
  input  logic                     pop,
  input  logic                     pop_two,
  output logic [$clog2(DEPTH):0]   count,
  output qent_t                    head,
  output logic [PM_DW-1:0]         next_word
);

  localparam int PW = $clog2(DEPTH);

  qent_t             entries [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       pop_n;
  logic [PW:0]       count_next;

  always_comb begin
    pop_n = '0;
    if (pop_two)
      pop_n = (PW+1)'(2);
    else if (pop)
      pop_n = (PW+1)'(1);
    count_next = count + (PW+1)'(push) - pop_n;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_two)
        rd_ptr <= rd_ptr + PW'(2);
      else if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      entries[wr_ptr] <= push_ent;
  end

  assign head      = entries[rd_ptr];
  assign next_word = entries[rd_ptr + PW'(1)].word;

endmodule

// File: rtl/prog_fetch_unit.sv
// AVR instruction fetch/prefetch: issues program-memory reads, queues the
// returned words and presents whole 16/32-bit instructions to the decoder.
module prog_fetch_unit
  import avr_core_pkg::*;
#(
  parameter int               QDEPTH   = 4,
  parameter logic [PM_AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PM_AW-1:0]  pm_addr,
  output logic              pm_re,
  input  logic [PM_DW-1:0]  pm_rdata,
  input  logic              hold,
  input  logic              redirect_valid,
  input  logic [PM_AW-1:0]  redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [PM_DW-1:0]  instr_w0,
  output logic [PM_DW-1:0]  instr_w1,
  output logic              instr_is32,
  output logic [PM_AW-1:0]  instr_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t      fetch_state;
  logic              inflight;
  logic [PM_AW-1:0]  inflight_pc;
  logic [PM_AW-1:0]  fetch_pc;
  logic [CW-1:0]     count;
  qent_t             head;
  logic [PM_DW-1:0]  next_word;
  logic              head_present;
  logic              head_is32;
  logic              capture;
  logic              pop;
  logic              pop_two;

  // In-flight requests reserve a slot so a returning word always has room.
  assign pm_re   = !rst && !hold &&
                   (((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(QDEPTH));
  assign pm_addr = fetch_pc;

  // A response issued during a redirect cycle returns during DRAIN and is dropped.
  assign capture = inflight && (fetch_state == RUN) && !redirect_valid;

  assign head_present = (count != '0);
  assign head_is32    = is_32bit_opcode(head.word);
  assign instr_valid  = head_present && (!head_is32 || (count >= CW'(2)));
  assign instr_w0     = head_present ? head.word : '0;
  assign instr_is32   = head_present && head_is32;
  assign instr_w1     = (instr_valid && head_is32) ? next_word : '0;
  assign instr_pc     = head_present ? head.pc : fetch_pc;

  assign pop     = instr_valid && instr_ready && !redirect_valid;
  assign pop_two = pop && head_is32;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_state <= RUN;
      inflight    <= 1'b0;
      fetch_pc    <= RESET_PC;
    end else begin
      inflight <= pm_re;
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        fetch_state <= pm_re ? DRAIN : RUN;
      end else begin
        fetch_state <= RUN;
        if (pm_re)
          fetch_pc <= fetch_pc + PM_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pm_re)
      inflight_pc <= fetch_pc;
  end

  prog_word_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (capture),
    .push_ent  ('{pc: inflight_pc, word: pm_rdata}),
    .pop       (pop),
    .pop_two   (pop_two),
    .count     (count),
    .head      (head),
    .next_word (next_word)
  );

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Self-checking bench for prog_fetch_unit: behavioural program memory plus an
// instruction scoreboard filled from the memory image.
module tb_prog_fetch_unit;

  localparam int QDEPTH = 4;

  typedef struct packed {
    logic [13:0] pc;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        is32;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] pm_addr;
  logic        pm_re;
  logic [15:0] pm_rdata = 16'h0;
  logic        hold = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [13:0] redirect_pc = 14'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_w0;
  logic [15:0] instr_w1;
  logic        instr_is32;
  logic [13:0] instr_pc;

  logic [15:0] mem [16384];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;

  prog_fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(14'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pm_addr        (pm_addr),
    .pm_re          (pm_re),
    .pm_rdata       (pm_rdata),
    .hold           (hold),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_w0       (instr_w0),
    .instr_w1       (instr_w1),
    .instr_is32     (instr_is32),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_re)
      pm_rdata <= mem[pm_addr];
  end

  function automatic bit tb_is32(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  function automatic void push_stream(input logic [13:0] start, input int n);
    logic [13:0] p;
    logic [13:0] q;
    exp_t        e;
    p = start;
    for (int i = 0; i < n; i++) begin
      q      = p + 14'd1;
      e.pc   = p;
      e.w0   = mem[p];
      e.is32 = tb_is32(mem[p]);
      e.w1   = e.is32 ? mem[q] : 16'h0;
      sb.push_back(e);
      p = e.is32 ? p + 14'd2 : q;
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
    sb.delete();
  endtask

  // Leaves the bench at the negedge that starts cycle 0 (rst just released).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hold = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pm_re !== 1'b0) begin errors++; $display("FAIL reset_pm_re: got %b expected 0", pm_re); end
    checks++; if (pm_addr !== 14'h0) begin errors++; $display("FAIL reset_pm_addr: got %h expected 0000", pm_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_w0 !== 16'h0) begin errors++; $display("FAIL reset_w0: got %h expected 0000", instr_w0); end
    checks++; if (instr_w1 !== 16'h0) begin errors++; $display("FAIL reset_w1: got %h expected 0000", instr_w1); end
    checks++; if (instr_is32 !== 1'b0) begin errors++; $display("FAIL reset_is32: got %b expected 0", instr_is32); end
    checks++; if (instr_pc !== 14'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", instr_pc); end
  endtask

  task automatic test_basic();
    exp_t e, o;
    int first_valid;
    clear_mem();
    mem[0] = 16'hE0EA; mem[1] = 16'hE0F0; mem[2] = 16'h010F;
    do_reset();
    push_stream(14'h0, 3);
    #1;
    checks++;
    if (pm_re !== 1'b1 || pm_addr !== 14'h0) begin
      errors++; $display("FAIL basic_first_req: got re=%b addr=%h expected re=1 addr=0000", pm_re, pm_addr);
    end
    first_valid = -1;
    for (int c = 1; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        if (first_valid < 0) first_valid = c;
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin
          errors++; $display("FAIL basic_instr: got pc=%h w0=%h w1=%h is32=%b expected pc=%h w0=%h w1=%h is32=%b",
                             o.pc, o.w0, o.w1, o.is32, e.pc, e.w0, e.w1, e.is32);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: %0d instructions missing expected 0", sb.size()); end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_latency: first valid cycle %0d expected 2", first_valid); end
  endtask

  task automatic test_call32();
    exp_t e, o;
    clear_mem();
    mem[0] = 16'h940E; mem[1] = 16'h0090; mem[2] = 16'hE0EA;
    do_reset();
    push_stream(14'h0, 2);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin
          errors++; $display("FAIL call32_instr: got pc=%h w0=%h w1=%h is32=%b expected pc=%h w0=%h w1=%h is32=%b",
                             o.pc, o.w0, o.w1, o.is32, e.pc, e.w0, e.w1, e.is32);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL call32_drain: %0d instructions missing expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    exp_t e, o;
    int issues;
    clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'hE000 + 16'(i);
    do_reset();
    #1; issues = int'(pm_re);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); #1; issues += int'(pm_re);
    end
    checks++; if (issues != QDEPTH) begin errors++; $display("FAIL bp_issue_count: got %0d expected %0d", issues, QDEPTH); end
    checks++; if (pm_re !== 1'b0) begin errors++; $display("FAIL bp_full_re: got %b expected 0", pm_re); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stalled: got %b expected 1", instr_valid); end
    push_stream(14'h0, 10);
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin
          errors++; $display("FAIL bp_instr: got pc=%h w0=%h expected pc=%h w0=%h", o.pc, o.w0, e.pc, e.w0);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d instructions missing expected 0", sb.size()); end
  endtask

  task automatic test_redirect();
    exp_t e, o;
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      mem[14'h90 + i] = 16'h2000 + 16'(i);
    end
    do_reset();
    push_stream(14'h0, 3);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin errors++; $display("FAIL redir_pre_instr: got pc=%h w0=%h expected pc=%h w0=%h", o.pc, o.w0, e.pc, e.w0); end
      end
    end
    @(negedge clk);
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 14'h0090;
    #1;
    checks++; if (pm_re !== 1'b1) begin errors++; $display("FAIL redir_inflight_req: got re=%b expected 1", pm_re); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_after: got %b expected 0", instr_valid); end
    checks++;
    if (pm_re !== 1'b1 || pm_addr !== 14'h0090) begin
      errors++; $display("FAIL redir_new_req: got re=%b addr=%h expected re=1 addr=0090", pm_re, pm_addr);
    end
    sb.delete();
    push_stream(14'h0090, 4);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin errors++; $display("FAIL redir_post_instr: got pc=%h w0=%h expected pc=%h w0=%h", o.pc, o.w0, e.pc, e.w0); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_drain: %0d instructions missing expected 0", sb.size()); end
  endtask

  task automatic test_hold();
    exp_t e, o;
    clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h3000 + 16'(i);
    do_reset();
    push_stream(14'h0, 12);
    for (int c = 1; c < 80 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; hold = (c >= 5 && c <= 7); #1;
      if (hold) begin
        checks++; if (pm_re !== 1'b0) begin errors++; $display("FAIL hold_no_req: cycle %0d got re=%b expected 0", c, pm_re); end
      end
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin errors++; $display("FAIL hold_instr: got pc=%h w0=%h expected pc=%h w0=%h", o.pc, o.w0, e.pc, e.w0); end
      end
    end
    hold = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL hold_drain: %0d instructions missing expected 0", sb.size()); end
  endtask

  task automatic test_wrap_and_reset();
    exp_t e, o;
    clear_mem();
    mem[14'h3FFF] = 16'h9200; mem[0] = 16'h1234; mem[1] = 16'hE0EA; mem[2] = 16'hE0F0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 14'h3FFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    push_stream(14'h3FFF, 3);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      if (instr_valid) begin
        e = sb.pop_front(); o = '{instr_pc, instr_w0, instr_w1, instr_is32}; checks++;
        if (o !== e) begin
          errors++; $display("FAIL wrap_instr: got pc=%h w0=%h w1=%h is32=%b expected pc=%h w0=%h w1=%h is32=%b",
                             o.pc, o.w0, o.w1, o.is32, e.pc, e.w0, e.w1, e.is32);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d instructions missing expected 0", sb.size()); end
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (pm_re !== 1'b0) begin errors++; $display("FAIL midrst_pm_re: got %b expected 0", pm_re); end
    checks++; if (pm_addr !== 14'h0) begin errors++; $display("FAIL midrst_pm_addr: got %h expected 0000", pm_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_w0 !== 16'h0) begin errors++; $display("FAIL midrst_w0: got %h expected 0000", instr_w0); end
    checks++; if (instr_w1 !== 16'h0) begin errors++; $display("FAIL midrst_w1: got %h expected 0000", instr_w1); end
    checks++; if (instr_is32 !== 1'b0) begin errors++; $display("FAIL midrst_is32: got %b expected 0", instr_is32); end
    checks++; if (instr_pc !== 14'h0) begin errors++; $display("FAIL midrst_pc: got %h expected 0000", instr_pc); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
    test_reset();
    test_basic();
    test_call32();
    test_backpressure();
    test_redirect();
    test_hold();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
- Instruction fetch and prefetch stage directly downstream of the program memory. It sits between the memory and the AVR decoder.
- Generates 14-bit word addresses and captures the 16-bit words returned one cycle later into a small word queue.
- Presents whole instructions to the decoder, joining 32-bit opcodes (LDS, STS, JMP, CALL) into one word pair.
- Supports redirect (branch, jump, interrupt vector) and a hold input so LPM/SPM can borrow the memory port.

Parameters:
- QDEPTH, 4, word-queue depth in 16-bit words; power of two, minimum 2.
- RESET_PC, 14'h0000, word address fetched after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pm_addr  out  14  program memory word address.
- pm_re  out  1  read request; the word at pm_addr returns on pm_rdata in the next cycle.
- pm_rdata  in  16  program memory read data (low byte = even byte address).
- hold  in  1  port borrowed by LPM/SPM; no new request may be issued while high.
- redirect_valid  in  1  flush the pipeline and restart fetching at redirect_pc.
- redirect_pc  in  14  new fetch word address.
- instr_valid  out  1  instruction available on instr_* outputs.
- instr_ready  in  1  decoder accepts the instruction this cycle.
- instr_w0  out  16  first opcode word.
- instr_w1  out  16  second word; valid only when instr_is32 = 1, otherwise 0.
- instr_is32  out  1  instruction is 32 bits long.
- instr_pc  out  14  word address of instr_w0.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC, queue empty, no request in flight.
  - pm_re = 0, pm_addr = RESET_PC, instr_valid = 0, instr_w0/w1 = 0, instr_is32 = 0, instr_pc = RESET_PC.
  - Reset overrides everything, including redirect_valid and requests in flight; the in-flight response is discarded.
- Request issue:
  - pm_re = 1 when hold = 0 and (queue count + inflight) < QDEPTH. pm_addr = fetch_pc.
  - fetch_pc increments modulo 2^14 on each issued request; 14'h3FFF wraps to 14'h0000.
- Response capture:
  - A request issued in cycle t writes pm_rdata into the queue at the edge ending cycle t+1.
  - Each queue entry stores its word address.
- Length decode (applied to the head word w):
  - is32 = ((w & 16'hFC0F) == 16'h9000) or ((w & 16'hFE0C) == 16'h940C).
  - This covers LDS, STS, JMP and CALL.
- Output:
  - instr_valid = queue non-empty and (not is32, or count >= 2).
  - Outputs are driven combinationally from registered queue state.
  - Pop on instr_valid & instr_ready: 1 word, or 2 words when is32.
- Latency:
  - rst low at cycle 0 → request addr 0 in cycle 0, data captured end of cycle 1, instr_valid in cycle 2.
  - Redirect accepted in cycle t → request to redirect_pc in cycle t+1, instr_valid no earlier than t+3.
- Redirect (priority over pop, issue and capture in the same cycle):
  - Clears the queue and sets fetch_pc = redirect_pc.
  - Marks any in-flight response as discard; the response arriving in cycle t+1 is dropped.
  - instr_valid = 0 in cycle t+1.
- hold:
  - Suppresses new requests only.
  - A response already in flight is still captured; queued instructions still drain.
- Full queue: no request is issued. Empty queue: instr_valid = 0. Simultaneous pop and capture in the same cycle are both honoured.
- 32-bit opcode at 14'h3FFF: its second word comes from 14'h0000 (wrap applies).
- State machine fetch_state:
  - RUN: normal operation.
  - DRAIN: entered on redirect while a request is in flight; lasts exactly 1 cycle, then returns to RUN. While in DRAIN, issuing may already proceed to redirect_pc.

Decomposition:
- Shared package avr_core_pkg:
  - PM_AW = 14, PM_DW = 16.
  - Opcode mask/match constants OPC32_LDSTS_MASK/MATCH and OPC32_JMPCALL_MASK/MATCH.
  - typedef fetch_state_t {RUN, DRAIN}.
  - Function is_32bit_opcode().
- One sub-module, prog_word_queue: a parameterised circular FIFO of {pc, word} with 1- or 2-word pop, count output and clear input.

Test Plan:
- Reset, then memory holds 16'hE0EA, 16'hE0F0, 16'h010F → three 16-bit instructions, pc 0, 1, 2; first instr_valid at cycle 2 after reset release.
- Word 0 = 16'h940E (CALL), word 1 = 16'h0090 → single instruction with instr_is32 = 1, instr_w1 = 16'h0090, instr_pc = 0; next instr_pc = 2.
- instr_ready held low for 10 cycles → exactly QDEPTH words queued, pm_re low once full, no word lost or duplicated after ready rises.
- redirect_valid with redirect_pc = 14'h0090 while a request is in flight → stale word dropped, next accepted instr_pc = 14'h0090.
- hold high for 3 cycles mid-stream → no pm_re during hold, in-flight word still captured, instruction order unchanged.
- redirect_pc = 14'h3FFF holding 16'h9200 (STS) → instr_w1 taken from address 0, instr_is32 = 1; rst asserted mid-fetch → all outputs return to reset values next cycle.
